// File: rtl/validity_pair_src.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : validity_pair_src
//  Purpose  : Producer end of the validity_reg checker interface. Buffers
//             6-bit pair words from an upstream valid/ready stream in a small
//             FIFO. Issues them as registered input0/input1 pairs, one per
//             cycle. Scores the delayed validity_reg response into saturating
//             pass/fail tallies.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   system clock, rising edge
//    reset        in   1   asynchronous, active-low reset
//    en           in   1   run enable (level)
//    in_valid     in   1   upstream word valid
//    in_data      in   6   [5:3] -> input0, [2:0] -> input1
//    in_ready     out  1   FIFO not full
//    input0       out  3   pair element 0 (registered)
//    input1       out  3   pair element 1 (registered)
//    validity_reg in   1   checker response
//    busy         out  1   state is not IDLE
//    done         out  1   one-cycle pulse on DRAIN->IDLE
//    pass_cnt     out  16  tagged responses equal to 1 (saturating)
//    fail_cnt     out  16  tagged responses equal to 0 (saturating)
//    first_fail   out  7   {valid, input0, input1} of the first failing pair
//  Parameters
//    DEPTH (power of two, 2..16), RSP_LAT (1..4), IDLE_CODE
//  Optional feature macro
//    VALIDITY_PAIR_SRC_FAIL_CAPTURE_EN : enables the first-failure capture
//    pipe. When undefined, first_fail is tied to zero.
// ============================================================================
module validity_pair_src #(
    parameter int         DEPTH     = 4,
    parameter int         RSP_LAT   = 1,
    parameter logic [2:0] IDLE_CODE = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        in_valid,
    input  logic [5:0]  in_data,
    output logic        in_ready,
    output logic [2:0]  input0,
    output logic [2:0]  input1,
    input  logic        validity_reg,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [6:0]  first_fail
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [5:0]  IDLE_PAIR = {IDLE_CODE, IDLE_CODE};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra bit so full and empty are distinct.
    // ------------------------------------------------------------------
    logic [5:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count;
    logic        full, empty, push, pop;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // Storage has no reset; occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [RSP_LAT-1:0] tag_q, tag_d;
    logic [RSP_LAT:0]   tag_ext;
    logic [5:0]         pair_q, pair_d;
    logic               done_q, done_d;
    logic               score;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en)  state_d = ST_SEND;
            ST_SEND:  if (!en) state_d = ST_DRAIN;
            // en is ignored here; leave only once nothing is in flight.
            ST_DRAIN: if (tag_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop    = (state_q == ST_SEND) && en && !empty;
        pair_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : IDLE_PAIR;
        done_d = (state_q == ST_DRAIN) && (tag_q == '0);
    end

    // Tag pipe: stage 0 marks a real pair, bubbles shift in zero.
    assign tag_ext = {tag_q, pop};
    assign tag_d   = tag_ext[RSP_LAT-1:0];
    assign score   = tag_q[RSP_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_q   <= IDLE_PAIR;
            tag_q    <= '0;
            done_q   <= 1'b0;
            pass_cnt <= 16'd0;
            fail_cnt <= 16'd0;
        end else begin
            pair_q <= pair_d;
            tag_q  <= tag_d;
            done_q <= done_d;
            if (score) begin
                if (validity_reg) begin
                    if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                end else begin
                    if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
                end
            end
        end
    end

    assign input0 = pair_q[5:3];
    assign input1 = pair_q[2:0];
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

    // ------------------------------------------------------------------
    // First-failure capture
    // ------------------------------------------------------------------
`ifdef VALIDITY_PAIR_SRC_FAIL_CAPTURE_EN
    // Copy pipe runs in lockstep with the tag pipe, so the last stage holds
    // the pair whose response is being scored this edge.
    logic [5:0] copy_q [RSP_LAT];
    logic [6:0] first_fail_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RSP_LAT; i++) copy_q[i] <= 6'd0;
            first_fail_q <= 7'd0;
        end else begin
            copy_q[0] <= pair_d;
            for (int i = 1; i < RSP_LAT; i++) copy_q[i] <= copy_q[i-1];
            if (score && !validity_reg && !first_fail_q[6]) begin
                first_fail_q <= {1'b1, copy_q[RSP_LAT-1]};
            end
        end
    end

    assign first_fail = first_fail_q;
`else
    assign first_fail = 7'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_validity_pair_src.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_validity_pair_src
//  Purpose  : Self-checking bench for validity_pair_src. Two instances
//             (RSP_LAT=1 and RSP_LAT=3) share stimulus and are compared every
//             cycle against a transaction-level model (queues plus issue
//             timestamps), with directed vectors for the corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_validity_pair_src;

    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_SEND = 1, M_DRAIN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = 6'd0;

    logic        d0_rdy, d0_busy, d0_done, d1_rdy, d1_busy, d1_done;
    logic [2:0]  d0_i0, d0_i1, d1_i0, d1_i1;
    logic [15:0] d0_pass, d0_fail, d1_pass, d1_fail;
    logic [6:0]  d0_ff, d1_ff;
    logic        vr0, vr1;
    logic [5:0]  h1 = 6'd0, h2 = 6'd0;

    bit rule_tbl [64];

    always #5 clk = ~clk;

    // Checker models: response for a pair becomes visible RSP_LAT-1 edges
    // after the pair appears, so it is valid at the RSP_LAT-th edge.
    assign vr0 = rule_tbl[{d0_i0, d0_i1}];
    always @(posedge clk) begin
        h1 <= {d1_i0, d1_i1};
        h2 <= h1;
    end
    assign vr1 = rule_tbl[h2];

    validity_pair_src #(.DEPTH(DEPTH), .RSP_LAT(1), .IDLE_CODE(3'b000)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d0_rdy), .input0(d0_i0), .input1(d0_i1), .validity_reg(vr0),
        .busy(d0_busy), .done(d0_done), .pass_cnt(d0_pass), .fail_cnt(d0_fail),
        .first_fail(d0_ff)
    );

    validity_pair_src #(.DEPTH(DEPTH), .RSP_LAT(3), .IDLE_CODE(3'b000)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d1_rdy), .input0(d1_i0), .input1(d1_i1), .validity_reg(vr1),
        .busy(d1_busy), .done(d1_done), .pass_cnt(d1_pass), .fail_cnt(d1_fail),
        .first_fail(d1_ff)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- reference model ----------------
    int         m_st   [2];
    logic [5:0] m_fifo [2][$];
    int         m_pt   [2][$];
    logic [5:0] m_pp   [2][$];
    logic [5:0] m_pair [2];
    int         m_pass [2];
    int         m_fail [2];
    logic [6:0] m_ff   [2];
    logic       m_done [2];

    task automatic model_reset(input int i);
        m_fifo[i].delete();
        m_pt[i].delete();
        m_pp[i].delete();
        m_st[i] = M_IDLE;
        m_pair[i] = 6'd0;
        m_pass[i] = 0;
        m_fail[i] = 0;
        m_ff[i] = 7'd0;
        m_done[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input int lat);
        int inflight;
        bit rdy;
        bit pop;
        logic [5:0] w;
        inflight = m_pt[i].size();
        rdy = (m_fifo[i].size() < DEPTH);
        m_done[i] = 1'b0;
        if (inflight > 0 && m_pt[i][0] + lat == cyc) begin
            w = m_pp[i][0];
            void'(m_pt[i].pop_front());
            void'(m_pp[i].pop_front());
            if (rule_tbl[w]) begin
                if (m_pass[i] < 65535) m_pass[i]++;
            end else begin
                if (m_fail[i] < 65535) m_fail[i]++;
                if (!m_ff[i][6]) m_ff[i] = {1'b1, w};
            end
        end
        pop = (m_st[i] == M_SEND) && en && (m_fifo[i].size() > 0);
        if (pop) begin
            w = m_fifo[i].pop_front();
            m_pair[i] = w;
            m_pt[i].push_back(cyc);
            m_pp[i].push_back(w);
        end else begin
            m_pair[i] = 6'd0;
        end
        if (in_valid && rdy) m_fifo[i].push_back(in_data);
        case (m_st[i])
            M_IDLE:  if (en) m_st[i] = M_SEND;
            M_SEND:  if (!en) m_st[i] = M_DRAIN;
            default: if (inflight == 0) begin
                         m_st[i] = M_IDLE;
                         m_done[i] = 1'b1;
                     end
        endcase
    endtask

    function automatic logic [47:0] dut_snap(input int i);
        if (i == 0)
            return {d0_rdy, d0_busy, d0_done, d0_i0, d0_i1, d0_pass, d0_fail, d0_ff};
        return {d1_rdy, d1_busy, d1_done, d1_i0, d1_i1, d1_pass, d1_fail, d1_ff};
    endfunction

    function automatic logic [47:0] mod_snap(input int i);
        logic [6:0] ff;
`ifdef VALIDITY_PAIR_SRC_FAIL_CAPTURE_EN
        ff = m_ff[i];
`else
        ff = 7'd0;
`endif
        return {(m_fifo[i].size() < DEPTH) ? 1'b1 : 1'b0, (m_st[i] != M_IDLE) ? 1'b1 : 1'b0,
                m_done[i], m_pair[i], 16'(m_pass[i]), 16'(m_fail[i]), ff};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++)
            chk($sformatf("cyc%0d_inst%0d", cyc, i), 64'(dut_snap(i)), 64'(mod_snap(i)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_step(0, 1);
            model_step(1, 3);
        end
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    localparam logic [47:0] RESET_SNAP = {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 16'd0, 7'd0};

    // Called at a negedge; asserts reset between edges and checks at once.
    task automatic do_reset(input string name);
        #2;
        reset = 1'b0;
        en = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        chk({name, "_inst0"}, 64'(dut_snap(0)), 64'(RESET_SNAP));
        chk({name, "_inst1"}, 64'(dut_snap(1)), 64'(RESET_SNAP));
        @(negedge clk);
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        en = 1'b0;
        in_valid = 1'b0;
        while ((d0_busy || d1_busy) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'({d0_busy, d1_busy}), 64'd0);
    endtask

    task automatic push_word(input logic [5:0] w);
        in_valid = 1'b1;
        in_data = w;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        en;
        logic        vld;
        logic [5:0]  data;
        logic [2:0]  e_i0;
        logic [2:0]  e_i1;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_pass;
        logic [15:0] e_fail;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base0, base1, seen;
        logic [5:0] got [$];
        logic [5:0] bpw [5];
        logic acc;

        for (int k = 0; k < 64; k++) rule_tbl[k] = 1'($urandom_range(0, 1));
        rule_tbl[6'o12] = 1'b1;
        rule_tbl[6'o34] = 1'b0;
        rule_tbl[6'o56] = 1'b1;
        rule_tbl[6'o71] = 1'b0;
        model_reset(0);
        model_reset(1);

        //             en   vld  data   i0 i1  rdy busy done pass fail
        tbl[0]  = '{1'b0, 1'b1, 6'o12, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 6'o34, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 6'o56, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 6'o00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 6'o00, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 6'o00, 3'd3, 3'd4, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0};
        tbl[6]  = '{1'b1, 1'b0, 6'o00, 3'd5, 3'd6, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1};
        tbl[7]  = '{1'b1, 1'b0, 6'o00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 6'o00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 6'o00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd1};
        tbl[10] = '{1'b0, 1'b0, 6'o00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1};

        // Reset values, then hold en=0 with no change.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_inst0", 64'(dut_snap(0)), 64'(RESET_SNAP));
        chk("reset_inst1", 64'(dut_snap(1)), 64'(RESET_SNAP));
        @(negedge clk);
        reset = 1'b1;
        repeat (10) tick();
        chk("idle_hold", 64'(dut_snap(0)), 64'(RESET_SNAP));

        // Basic run on the RSP_LAT=1 instance.
        for (int r = 0; r < 11; r++) begin
            en = tbl[r].en;
            in_valid = tbl[r].vld;
            in_data = tbl[r].data;
            tick();
            chk($sformatf("basic_row%0d", r),
                64'({d0_i0, d0_i1, d0_rdy, d0_busy, d0_done, d0_pass, d0_fail}),
                64'({tbl[r].e_i0, tbl[r].e_i1, tbl[r].e_rdy, tbl[r].e_busy,
                     tbl[r].e_done, tbl[r].e_pass, tbl[r].e_fail}));
        end
        wait_idle("basic");

        // Backpressure: fill the FIFO, 5th word held until space appears.
        bpw[0] = 6'o11; bpw[1] = 6'o22; bpw[2] = 6'o33; bpw[3] = 6'o44; bpw[4] = 6'o55;
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_word(bpw[k]);
            chk($sformatf("bp_ready%0d", k), 64'(d0_rdy), (k < 3) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b1;
        in_data = bpw[4];
        repeat (2) tick();
        chk("bp_held", 64'({d0_rdy, d1_rdy}), 64'd0);
        en = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && seen < 5; n++) begin
            acc = in_valid && d0_rdy;
            tick();
            if (acc) in_valid = 1'b0;
            if ({d0_i0, d0_i1} != 6'd0) begin
                got.push_back({d0_i0, d0_i1});
                seen++;
            end
        end
        chk("bp_count", 64'(seen), 64'd5);
        for (int k = 0; k < got.size() && k < 5; k++)
            chk($sformatf("bp_order%0d", k), 64'(got[k]), 64'(bpw[k]));
        wait_idle("bp");

        // Bubbles: one word every third cycle while running.
        base0 = m_pass[0] + m_fail[0];
        base1 = m_pass[1] + m_fail[1];
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_word(6'($urandom_range(1, 63)));
            repeat (2) tick();
        end
        repeat (4) tick();
        wait_idle("bubble");
        chk("bubble_total0", 64'(d0_pass + d0_fail), 64'(base0 + 5));
        chk("bubble_total1", 64'(d1_pass + d1_fail), 64'(base1 + 5));

        // Drain and done on the RSP_LAT=3 instance.
        base1 = m_pass[1] + m_fail[1];
        en = 1'b0;
        for (int k = 0; k < 3; k++) push_word(6'($urandom_range(1, 63)));
        en = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && seen < 3; n++) begin
            tick();
            if ({d1_i0, d1_i1} != 6'd0) seen++;
        end
        chk("drain_pops", 64'(seen), 64'd3);
        en = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk($sformatf("drain_done_t%0d", t), 64'(d1_done), (t == 4) ? 64'd1 : 64'd0);
        end
        chk("drain_total1", 64'(d1_pass + d1_fail), 64'(base1 + 3));
        wait_idle("drain");

        // Randomized traffic with en toggling (including en=1 during DRAIN).
        en = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            in_valid = 1'($urandom_range(0, 1));
            in_data = 6'($urandom);
            tick();
        end
        wait_idle("random");

        // Fail capture from a fresh reset.
        do_reset("reset_stale");
        en = 1'b0;
        push_word(6'o12);
        push_word(6'o71);
        push_word(6'o34);
        en = 1'b1;
        repeat (5) tick();
        wait_idle("capture");
        chk("cap_counts0", 64'({d0_pass, d0_fail}), 64'({16'd1, 16'd2}));
        chk("cap_counts1", 64'({d1_pass, d1_fail}), 64'({16'd1, 16'd2}));
`ifdef VALIDITY_PAIR_SRC_FAIL_CAPTURE_EN
        chk("cap_first_fail0", 64'(d0_ff), 64'(7'b1_111_001));
        chk("cap_first_fail1", 64'(d1_ff), 64'(7'b1_111_001));
`else
        chk("cap_first_fail0", 64'(d0_ff), 64'd0);
        chk("cap_first_fail1", 64'(d1_ff), 64'd0);
`endif

        // Reset asserted in the middle of SEND.
        en = 1'b0;
        for (int k = 0; k < 4; k++) push_word(6'($urandom_range(1, 63)));
        en = 1'b1;
        repeat (3) tick();
        chk("midrun_busy", 64'({d0_busy, d1_busy}), 64'({1'b1, 1'b1}));
        do_reset("reset_midrun");
        repeat (5) tick();
        chk("post_reset_hold", 64'(dut_snap(0)), 64'(RESET_SNAP));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
